// File: rtl/peripheral_ahb_slave_ram_bb.sv
// peripheral_ahb_slave_ram_bb
//   AHB-Lite responder backed by an internal word-wide RAM. Accepts SINGLE,
//   INCR and WRAP bursts with byte/halfword/word writes through byte lanes.
//   Returns OKAY, or the two-cycle ERROR response for oversize, misaligned or
//   out-of-range transfers. Beat addresses always come from HADDR; the burst
//   type is not checked.
//
//   Optional feature macro: PERIPHERAL_AHB_SLAVE_WAITSTATE_EN
//     When defined, good transfers insert WAIT_STATES cycles with
//     HREADYOUT=0 before the data phase. WAIT_STATES=0 gives zero-wait.
//
// Ports
//   HCLK        clock, rising edge
//   HRESETn     synchronous active-low reset
//   HSEL        slave select from the decoder
//   HADDR       byte address
//   HWDATA      write data (data phase)
//   HRDATA      read data (data phase, zero otherwise)
//   HWRITE      1=write, 0=read
//   HSIZE       transfer size
//   HBURST      burst type (unused)
//   HPROT       protection (unused)
//   HTRANS      IDLE/BUSY/NONSEQ/SEQ
//   HMASTLOCK   lock (unused)
//   HREADY      bus-level ready
//   HREADYOUT   this slave's ready
//   HRESP       0=OKAY, 1=ERROR
module peripheral_ahb_slave_ram_bb #(
  parameter int HADDR_SIZE  = 16,
  parameter int HDATA_SIZE  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int BYTES = HDATA_SIZE / 8;
  localparam int BW    = $clog2(BYTES);
  localparam int IW    = $clog2(MEM_DEPTH);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DATA = 3'd1;
  localparam logic [2:0] ST_ERR1 = 3'd2;
  localparam logic [2:0] ST_ERR2 = 3'd3;

  logic [2:0]            state, state_nxt;
  logic                  can_take, accept, bad;
  logic [BW-1:0]         off, sz_mask;
  logic [BYTES-1:0]      be;
  logic                  in_wait;

  // Latched address-phase info for the data phase
  logic [IW-1:0]         a_idx;
  logic [BYTES-1:0]      a_be;
  logic                  a_write;

  logic [BYTES-1:0][7:0] mem [MEM_DEPTH];

  logic unused_ok;
  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

`ifdef PERIPHERAL_AHB_SLAVE_WAITSTATE_EN
  localparam logic [2:0] ST_WAIT = 3'd4;
  localparam logic [2:0] ST_GOOD = (WAIT_STATES == 0) ? ST_DATA : ST_WAIT;
  logic [3:0] wait_cnt;
  logic       wait_done;

  assign wait_done = (wait_cnt == 4'(WAIT_STATES - 1));
  assign in_wait   = (state == ST_WAIT);

  always_ff @(posedge HCLK) begin
    if (!HRESETn)                 wait_cnt <= '0;
    else if (in_wait && !wait_done) wait_cnt <= wait_cnt + 4'd1;
    else                          wait_cnt <= '0;
  end
`else
  localparam logic [2:0] ST_GOOD = ST_DATA;
  localparam int unused_wait_states = WAIT_STATES;
  assign in_wait = 1'b0;
`endif

  // New address phases are only taken once the previous data phase ends
  assign can_take = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
  assign accept   = can_take && HSEL && HREADY && HTRANS[1];

  assign off     = HADDR[BW-1:0];
  assign sz_mask = BW'((32'd1 << HSIZE) - 32'd1);
  // Range check relies on MEM_DEPTH*BYTES being a power of two
  assign bad     = (32'(HSIZE) > BW) || (|(off & sz_mask)) || (|(HADDR >> (BW + IW)));

  always_comb begin
    be = '0;
    for (int i = 0; i < BYTES; i++)
      be[i] = (i >= int'(off)) && (i < int'(off) + (1 << HSIZE));
  end

  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_ERR1: state_nxt = ST_ERR2;
`ifdef PERIPHERAL_AHB_SLAVE_WAITSTATE_EN
      ST_WAIT: state_nxt = wait_done ? ST_DATA : ST_WAIT;
`endif
      default: state_nxt = accept ? (bad ? ST_ERR1 : ST_GOOD) : ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state   <= ST_IDLE;
      a_idx   <= '0;
      a_be    <= '0;
      a_write <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_idx   <= HADDR[BW+IW-1:BW];
        a_be    <= be;
        a_write <= HWRITE;
      end
    end
  end

  // Write commits at the end of the ready data-phase cycle, so a read in the
  // very next data phase already sees the merged word (no bypass needed).
  // A reset landing on that edge drops the write.
  always_ff @(posedge HCLK) begin
    if (HRESETn && (state == ST_DATA) && a_write)
      for (int b = 0; b < BYTES; b++)
        if (a_be[b]) mem[a_idx][b] <= HWDATA[b*8 +: 8];
  end

  assign HRDATA    = ((state == ST_DATA) && !a_write) ? mem[a_idx] : '0;
  assign HREADYOUT = !((state == ST_ERR1) || in_wait);
  assign HRESP     = (state == ST_ERR1) || (state == ST_ERR2);

endmodule
